// File: rtl/ws2812_frame_if.sv
// ws2812_frame_if: host write port plus serializer handshake for ws2812_frame.
// Signals: wr_en/wr_addr/wr_data/update in from host, busy out to host;
// tx_start/tx_data out to the serializer, tx_bsy back from it.
// master = host + serializer side, slave = ws2812_frame.
interface ws2812_frame_if #(
  parameter int N_LEDS = 8
);
  localparam int AW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          update;
  logic          busy;
  logic          tx_start;
  logic [23:0]   tx_data;
  logic          tx_bsy;

  modport master (
    output wr_en, wr_addr, wr_data, update, tx_bsy,
    input  busy, tx_start, tx_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, update, tx_bsy,
    output busy, tx_start, tx_data
  );
endinterface

// File: rtl/ws2812_frame.sv
// ws2812_frame: double-buffered WS2812 frame source feeding ws2812_tx.
// Ports: clk, rst (async active-low), bus (ws2812_frame_if.slave), and
// brightness[7:0] only when WS2812_FRAME_BRIGHTNESS_EN is defined.
// Host writes the back buffer; update snapshots it into the front buffer and
// streams one word per LED, then holds busy through the latch gap.
module ws2812_frame #(
  parameter real F_CLK   = 48e6,
  parameter int  N_LEDS  = 8,
  parameter real T_RESET = 80e-6
) (
  input logic clk,
  input logic rst,
`ifdef WS2812_FRAME_BRIGHTNESS_EN
  input logic [7:0] brightness,
`endif
  ws2812_frame_if.slave bus
);

  localparam int AW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  // Small epsilon keeps floating-point noise in T_RESET*F_CLK from adding a cycle.
  localparam int N_GAP = int'($ceil(T_RESET * F_CLK - 1.0e-6));
  localparam int CW = $clog2(N_GAP);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_TX, LATCH} state_t;

  state_t        state;
  logic [AW-1:0] idx;
  logic [CW-1:0] cnt;
  logic          pending;
  logic          tx_start_q;
  logic          busy_q;

  logic [23:0] back  [N_LEDS];
  logic [23:0] front [N_LEDS];

  logic        cnt_last;
  logic        idx_last;
  logic        snap;
  logic [23:0] word_out;

  assign cnt_last = (cnt == CW'(N_GAP - 1));
  assign idx_last = (idx == AW'(N_LEDS - 1));

  // Snapshot from IDLE on update, or at the end of the latch gap when a
  // request is pending (an update landing on that very cycle counts too).
  always_comb begin
    snap = 1'b0;
    if (state == IDLE && bus.update)
      snap = 1'b1;
    else if (state == LATCH && cnt_last && (pending || bus.update))
      snap = 1'b1;
  end

  // Back buffer: addresses with no matching LED simply never hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_LEDS; i++) back[i] <= 24'd0;
    end else begin
      for (int i = 0; i < N_LEDS; i++)
        if (bus.wr_en && bus.wr_addr == AW'(i)) back[i] <= bus.wr_data;
    end
  end

  // Front buffer: copy of back, with a same-cycle write bypassed in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_LEDS; i++) front[i] <= 24'd0;
    end else if (snap) begin
      for (int i = 0; i < N_LEDS; i++)
        front[i] <= (bus.wr_en && bus.wr_addr == AW'(i)) ? bus.wr_data : back[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      pending    <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // One-deep request latch; repeated updates merge.
      if (bus.update && state != IDLE) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.update) begin
            idx        <= '0;
            state      <= LOAD;
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        LOAD: begin
          state <= START;
        end
        START: begin
          state      <= WAIT_TX;
          tx_start_q <= 1'b0;
        end
        WAIT_TX: begin
          if (!bus.tx_bsy) begin
            if (idx_last) begin
              state <= LATCH;
              cnt   <= '0;
            end else begin
              idx        <= idx + AW'(1);
              state      <= LOAD;
              tx_start_q <= 1'b1;
            end
          end
        end
        LATCH: begin
          if (cnt_last) begin
            if (pending || bus.update) begin
              // Back-to-back frame: busy stays high.
              pending    <= 1'b0;
              idx        <= '0;
              state      <= LOAD;
              tx_start_q <= 1'b1;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state      <= IDLE;
          tx_start_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

`ifdef WS2812_FRAME_BRIGHTNESS_EN
  // (c * (b+1)) >> 8: product fits 16 bits, so bits [15:8] are the result.
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [16:0] p;
    p = {9'd0, c} * {8'd0, ({1'b0, b} + 9'd1)};
    return p[15:8];
  endfunction

  always_comb begin
    word_out = {scale(front[idx][23:16], brightness),
                scale(front[idx][15:8],  brightness),
                scale(front[idx][7:0],   brightness)};
  end
`else
  always_comb begin
    word_out = front[idx];
  end
`endif

  assign bus.tx_start = tx_start_q;
  assign bus.busy     = busy_q;
  assign bus.tx_data  = word_out;

endmodule
